// File: rtl/pll_rsp_pkg.sv
// pll_rsp_pkg: shared types and status-word layout for the PLL reset responder.
package pll_rsp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RST_ASSERT = 3'd1,
    ST_WAIT_LOCK  = 3'd2,
    ST_HOLD       = 3'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_PULSE   = 2'd1,
    OP_HOLD    = 2'd2,
    OP_RELEASE = 2'd3
  } op_t;

  localparam logic [7:0] MAGIC = 8'hA5;

  localparam int unsigned ECHO_LSB    = 0;
  localparam int unsigned BUSY_BIT    = 8;
  localparam int unsigned LOCKED_BIT  = 9;
  localparam int unsigned TIMEOUT_BIT = 10;
  localparam int unsigned LOST_BIT    = 11;
  localparam int unsigned RESET_BIT   = 12;
  localparam int unsigned STATE_LSB   = 13;
  localparam int unsigned LAT_LSB     = 16;

  function automatic logic is_busy(state_t s);
    return s == ST_RST_ASSERT || s == ST_WAIT_LOCK;
  endfunction

endpackage

// File: rtl/pll_reset_responder_sync.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else        {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_reset_responder.sv
// pll_reset_responder: decodes PIO reset commands, sequences PLL reset and
// reports qualified lock status back through a registered status word.
module pll_reset_responder
  import pll_rsp_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT    = 65535,
  parameter int unsigned LOCK_STABLE     = 8
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] cmd_word,
  input  logic        pll_locked,
  output logic        pll_reset,
  output logic [31:0] status_word
);

  state_t      state, state_nx;
  logic [17:0] cmd_q;
  logic [7:0]  last_seq, pend_seq, echo, seq;
  logic [15:0] lat, lat_inc, lat_cap, stab, hold_cnt;
  logic        timeout, lock_lost, busy, locked_sync, ls_d;
  logic        accept, done_now, clr_to, clr_lost, hold_done, lock_ok, lat_done, wl_exit;
  logic        unused_bits;
  op_t         op;

  assign unused_bits = ^cmd_word[23:10];

  sync_2ff u_sync (
    .clk  (clk_clk),
    .rst_n(reset_reset_n),
    .d    (pll_locked),
    .q    (locked_sync)
  );

  assign op        = op_t'(cmd_q[9:8]);
  assign seq       = cmd_q[7:0];
  assign accept    = cmd_q[17:10] == MAGIC && seq != last_seq && (state == ST_IDLE || state == ST_HOLD);
  assign done_now  = accept && (op == OP_NOP || op == OP_HOLD || (op == OP_RELEASE && state == ST_IDLE));
  assign clr_to    = accept && (op == OP_PULSE || op == OP_RELEASE);
  assign clr_lost  = accept && op == OP_PULSE;
  assign hold_done = state == ST_RST_ASSERT && hold_cnt == 16'(RST_HOLD_CYCLES - 1);
  assign lat_inc   = lat == 16'hFFFF ? lat : lat + 16'd1;
  // Lock qualification takes priority over a timeout landing in the same cycle.
  assign lock_ok   = state == ST_WAIT_LOCK && locked_sync && stab == 16'(LOCK_STABLE - 1);
  assign lat_done  = state == ST_WAIT_LOCK && ({1'b0, lat} + 17'd1) >= 17'(LOCK_TIMEOUT);
  assign wl_exit   = lock_ok || lat_done;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE, ST_HOLD:
        state_nx = !accept                                  ? state :
                   op == OP_PULSE                           ? ST_RST_ASSERT :
                   op == OP_HOLD                            ? ST_HOLD :
                   (op == OP_RELEASE && state == ST_HOLD)   ? ST_WAIT_LOCK : state;
      ST_RST_ASSERT: state_nx = hold_done ? ST_WAIT_LOCK : state;
      ST_WAIT_LOCK:  state_nx = wl_exit ? ST_IDLE : state;
      default:       state_nx = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= ST_HOLD;
      pll_reset <= 1'b1;
      busy      <= 1'b0;
      cmd_q     <= '0;
      last_seq  <= '0;
      pend_seq  <= '0;
      echo      <= '0;
      timeout   <= 1'b0;
      lock_lost <= 1'b0;
      lat       <= '0;
      lat_cap   <= '0;
      stab      <= '0;
      hold_cnt  <= '0;
      ls_d      <= 1'b0;
    end else begin
      state     <= state_nx;
      pll_reset <= state_nx == ST_RST_ASSERT || state_nx == ST_HOLD;
      busy      <= is_busy(state_nx);
      cmd_q     <= {cmd_word[31:24], cmd_word[9:0]};
      last_seq  <= accept ? seq : last_seq;
      pend_seq  <= accept ? seq : pend_seq;
      echo      <= done_now ? seq : wl_exit ? pend_seq : echo;
      timeout   <= (timeout && !clr_to) || (lat_done && !lock_ok);
      lock_lost <= clr_lost ? 1'b0 : lock_lost || (state == ST_IDLE && ls_d && !locked_sync);
      lat       <= state == ST_WAIT_LOCK ? lat_inc : 16'd0;
      lat_cap   <= wl_exit ? lat_inc : lat_cap;
      stab      <= state == ST_WAIT_LOCK && locked_sync ? stab + 16'd1 : 16'd0;
      hold_cnt  <= state == ST_RST_ASSERT ? hold_cnt + 16'd1 : 16'd0;
      ls_d      <= locked_sync;
    end
  end

  // Every field comes straight from a flop; no input reaches status_word combinationally.
  always_comb begin
    status_word                       = '0;
    status_word[ECHO_LSB +: 8]        = echo;
    status_word[BUSY_BIT]             = busy;
    status_word[LOCKED_BIT]           = locked_sync;
    status_word[TIMEOUT_BIT]          = timeout;
    status_word[LOST_BIT]             = lock_lost;
    status_word[RESET_BIT]            = pll_reset;
    status_word[STATE_LSB +: 3]       = state;
    status_word[LAT_LSB +: 16]        = lat_cap;
  end

endmodule

// File: tb/tb_pll_reset_responder.sv
// tb_pll_reset_responder: scoreboard bench; commands push expected completions,
// a negedge monitor pops and checks them whenever the echoed seq changes.
module tb_pll_reset_responder;

  localparam int HOLDC = 16;
  localparam int TMO   = 100;
  localparam int STAB  = 8;
  localparam int NOGL  = -100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pll_locked = 1'b0;
  logic [31:0] cmd_word = '0;
  logic        pll_reset;
  logic [31:0] status_word;

  pll_reset_responder #(
    .RST_HOLD_CYCLES(HOLDC),
    .LOCK_TIMEOUT   (TMO),
    .LOCK_STABLE    (STAB)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .cmd_word     (cmd_word),
    .pll_locked   (pll_locked),
    .pll_reset    (pll_reset),
    .status_word  (status_word)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] st;
    int          at;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int total = 0;
  int bad = 0;

  int          m_state;
  logic [7:0]  m_last, m_echo;
  logic [15:0] m_lat;
  bit          m_to, m_lost, m_ls;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {m_lat, 3'(m_state), m_state == 3, m_lost, m_to, m_ls, 1'b0, m_echo};
  endfunction

  function automatic void m_reset();
    m_state = 3; m_last = 0; m_echo = 0; m_lat = 0; m_to = 0; m_lost = 0; m_ls = 0;
  endfunction

  // pll_locked level at edge (first WAIT_LOCK edge + j): high after k, except a glitch at g.
  function automatic bit lval(int j, int k, int g);
    return j > k && j != g;
  endfunction

  // Cycles spent waiting: synchronised level lags the pin by two edges.
  function automatic int wl_len(int k, int g, output bit locked);
    int run = 0;
    for (int c = 1; c <= TMO; c++) begin
      run = lval(c - 2, k, g) ? run + 1 : 0;
      if (run == STAB) begin
        locked = 1;
        return c;
      end
    end
    locked = 0;
    return TMO;
  endfunction

  logic [7:0] prev_echo = 0;
  always @(negedge clk) begin
    if (!rst_n) prev_echo = 0;
    else if (status_word[7:0] != prev_echo) begin
      prev_echo = status_word[7:0];
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_completion: got %h want none", status_word);
      end else begin
        mon_e = q.pop_front();
        chk("completion_status", status_word, mon_e.st);
        chk("completion_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask

  task automatic send(logic [31:0] w, int k, int g, logic [7:0] late);
    logic [7:0] seq;
    int op, x, off, n, span;
    bit lk;
    seq = w[7:0];
    op  = int'(w[9:8]);
    @(negedge clk);
    cmd_word = w;
    x = cyc + 1;
    if (w[31:24] != 8'hA5 || seq == m_last) begin
      repeat (4) @(negedge clk);
      chk("ignored_cmd", status_word, m_status());
    end else begin
      m_last = seq;
      if (op == 1 || op == 3) m_to = 0;
      if (op == 1) m_lost = 0;
      if (op == 0 || op == 2 || (op == 3 && m_state == 0)) begin
        m_echo = seq;
        if (op == 2) m_state = 3;
        q.push_back('{m_status(), x + 1});
        if (op == 2) begin
          @(negedge clk);
          pll_locked = 0;
          m_ls = 0;
        end
        repeat (4) @(negedge clk);
      end else begin
        off = op == 1 ? HOLDC + 1 : 1;
        n = wl_len(k, g, lk);
        m_state = 0; m_lat = 16'(n); m_to = !lk; m_echo = seq; m_ls = lval(n - 1, k, g);
        q.push_back('{m_status(), x + off + n});
        if (late != 0 && late != seq) begin
          m_last = late; m_echo = late; m_ls = lval(n, k, g);
          q.push_back('{m_status(), x + off + n + 1});
        end
        span = off + n + 3;
        for (int e = 1; e <= span; e++) begin
          @(negedge clk);
          pll_locked = lval(e - off, k, g);
          if (late != 0 && e == 5) cmd_word = {8'hA5, 14'd0, 2'd0, late};
        end
      end
      drain();
    end
  endtask

  task automatic drop_lock();
    @(negedge clk);
    pll_locked = 0;
    repeat (5) @(negedge clk);
    if (m_state == 0 && m_ls) m_lost = 1;
    m_ls = 0;
    chk("lock_lost_idle", status_word, m_status());
  endtask

  initial begin
    logic [7:0] s;
    int op, k, g;
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("reset_status", status_word, 32'h0000_7000);
    chk("reset_pll_reset", {31'd0, pll_reset}, 32'd1);

    send(32'hA500_0101, 10, NOGL, 8'h00);
    chk("pulse_status_const", status_word, 32'h0014_0201);
    send(32'hA500_0207, 0, NOGL, 8'h00);
    chk("hold_pll_reset", {31'd0, pll_reset}, 32'd1);
    send(32'hA500_0302, 1000, NOGL, 8'h00);
    chk("timeout_status_const", status_word, 32'h0064_0402);
    chk("timeout_pll_reset", {31'd0, pll_reset}, 32'd0);

    send(32'hA500_0104, 5, NOGL, 8'h06);
    send(32'hB500_0105, 0, NOGL, 8'h00);
    send(32'hA500_0006, 0, NOGL, 8'h00);
    send(32'hA500_0109, 4, 10, 8'h00);
    send(32'hA500_010A, TMO - 10, NOGL, 8'h00);
    drop_lock();
    send(32'hA500_000B, 0, NOGL, 8'h00);
    send(32'hA500_030C, 0, NOGL, 8'h00);

    for (int i = 0; i < 12; i++) begin
      op = $urandom_range(0, 3);
      do s = 8'($urandom_range(1, 255)); while (s == m_last);
      k = $urandom_range(0, 4) == 0 ? 1000 : $urandom_range(0, 40);
      g = $urandom_range(0, 1) == 1 ? k + 1 + $urandom_range(0, 9) : NOGL;
      send({8'hA5, 14'd0, 2'(op), s}, k, g, 8'h00);
    end

    @(negedge clk);
    pll_locked = 0;
    cmd_word = 32'hA500_0131;
    repeat (HOLDC + 8) @(negedge clk);
    #2 rst_n = 0;
    cmd_word = '0;
    #1;
    chk("async_reset_status", status_word, 32'h0000_7000);
    chk("async_reset_pll_reset", {31'd0, pll_reset}, 32'd1);
    q.delete();
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_reset_status", status_word, 32'h0000_7000);
    send(32'hA500_0121, 3, NOGL, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
